start_fifo_srl_ctrl: RTL

- Controller and storage sequencer for the start-token and stream FIFOs between PE dataflow processes (for example, PE_i4xi4_pack start channels).
- Drives an SRL shift-register store. Pushing shifts the store; popping reads at an address given by the occupancy counter.
- Adds a registered show-ahead output stage and occupancy reporting.
- Replaces the per-channel ad-hoc FIFO glue. The producer sees a full_n interface; the consumer sees an empty_n interface.

---
 rtl/start_fifo_srl_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/start_fifo_srl_ctrl.sv
// start_fifo_srl_ctrl
// Shift-register FIFO for start tokens and stream data between PE dataflow
// processes. It has a registered show-ahead output stage. The producer sees
// a full_n handshake and the consumer sees an empty_n handshake. Total
// capacity is DEPTH entries in the SRL plus one in the output register.
module start_fifo_srl_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 10
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  localparam int CntW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] r_srl [DEPTH];
  logic [CntW-1:0]       r_srlCnt;
  logic                  r_outValid;
  logic [DATA_WIDTH-1:0] r_dout;

  logic                  w_fullN;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_srlHead;

  // Full comes straight from the counter register, so a read never reaches
  // the write side combinationally. A pop while full therefore frees a slot
  // only on the following cycle.
  assign w_fullN = (r_srlCnt != CntW'(DEPTH));
  assign w_push  = if_write_ce & if_write & w_fullN;
  assign w_pop   = if_read_ce & if_read & r_outValid;
  assign w_load  = (r_srlCnt != '0) & (~r_outValid | w_pop);

  // Shift store: the newest entry enters at index 0 and older entries move
  // up. The SRL contents are not reset.
  always_ff @(posedge ap_clk) begin
    if (w_push) begin
      r_srl[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) begin
        r_srl[i] <= r_srl[i-1];
      end
    end
  end

  // The oldest entry is at index srl_cnt-1 of the contents before the edge.
  // A push and a load in the same cycle still hand out the oldest entry.
  always_comb begin
    w_srlHead = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_srlCnt == CntW'(i + 1)) begin
        w_srlHead = r_srl[i];
      end
    end
  end

  // The occupancy counter stays in 0..DEPTH. A push and a load together
  // leave it unchanged.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_srlCnt <= '0;
    end else if (w_push && !w_load) begin
      r_srlCnt <= r_srlCnt + CntW'(1);
    end else if (!w_push && w_load) begin
      r_srlCnt <= r_srlCnt - CntW'(1);
    end
  end

  // Show-ahead output register. It loads the head whenever it is empty or
  // being consumed. A pop with nothing to load leaves the stale data in
  // place and only drops the valid flag.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_outValid <= 1'b0;
      r_dout     <= '0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_dout     <= w_srlHead;
    end else if (w_pop) begin
      r_outValid <= 1'b0;
    end
  end

  assign if_full_n         = w_fullN;
  assign if_dout           = r_dout;
  assign if_empty_n        = r_outValid;
  assign if_num_data_valid = r_srlCnt + CntW'(r_outValid);
  assign if_fifo_cap       = CntW'(DEPTH + 1);

endmodule
